delay_writer: RTL
=================

Name: delay_writer

Overview:
- Write side of the delay-line timestamp FIFO.
- Synchronises an asynchronous input pulse and detects its rising edge.
- On each edge, computes the target time `count + delay` (mod 2^WIDTH) and pushes it into the FIFO. The downstream reader fires its output when the free-running count reaches that value.
- Handles FIFO-full by dropping the event and flagging overflow. Provides a hold-off window that rejects input bounce.

Parameters:
- WIDTH, 8, width of count, delay and FIFO data.
- SYNC_STAGES, 2, synchroniser flops on pulse_in (minimum 2).
- HOLDOFF, 4, cycles after a write or drop during which new edges are ignored (0 = none).
- DROP_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- pulse_in  input  1  asynchronous event input.
- count  input  WIDTH  free-running timer shared with the FIFO reader.
- delay  input  WIDTH  delay in clk cycles; sampled on event acceptance.
- full  input  1  FIFO full flag.
- wr_en  output  1  FIFO write strobe, one cycle per accepted event.
- data_out  output  WIDTH  target time written to the FIFO.
- overflow  output  1  sticky: at least one event dropped because of full.
- drop_count  output  DROP_WIDTH  saturating count of dropped events.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-low on rst_n. All state updates on posedge clk.
  - While rst_n=0 at a clock edge: sync chain=0, edge-history flop=0, state=IDLE, wr_en=0, data_out=0, overflow=0, drop_count=0, holdoff counter=0.
- Synchronisation:
  - pulse_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~history. Because history resets to 0, an input held high through reset produces one rise after reset release.
- State machine (IDLE, WRITE, HOLD):
  - IDLE, rise, full=0: latch data_out = (count + delay) mod 2^WIDTH using values present at that edge; go to WRITE.
  - IDLE, rise, full=1: no write. overflow<=1; drop_count<=drop_count+1, saturating at all-ones. Go to HOLD, or stay in IDLE if HOLDOFF=0.
  - WRITE: wr_en=1 for exactly this cycle, with data_out stable. Next state is HOLD, or IDLE if HOLDOFF=0. Full is not rechecked in WRITE; the FIFO guarantees one free slot while full was low.
  - HOLD: counter loads HOLDOFF-1 on entry and decrements each cycle. Return to IDLE when it reaches 0. Rises during HOLD are ignored and not counted.
  - Rises during WRITE are ignored and not counted.
- wr_en is registered, i.e. high only while state==WRITE.
- data_out holds its last value between writes.
- Latency: a pulse_in rise meeting setup before edge k gives rise=1 after edge k+SYNC_STAGES. data_out is latched at edge k+SYNC_STAGES+1, and wr_en is high in the following cycle.
- Width and wrap: the sum is truncated to WIDTH bits, so count=250 with delay=10 gives 4 (WIDTH=8).
- delay=0 is legal; it writes the current count, and the reader treats that as a near-immediate or full-wrap match.
- Overflow clear:
  - clear_overflow=1 clears overflow and drop_count on that edge.
  - If a drop coincides with clear, the drop wins: overflow=1, drop_count=1.
- Pulse width: input pulses shorter than one clk period may be missed. This is documented, not flagged.
- Reset mid-operation: a pending WRITE is abandoned with no wr_en; any latched data is discarded.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, pulse_in=0 → all outputs 0; wr_en never asserts over 50 cycles.
- Single event: WIDTH=8, delay=20, pulse_in rises when count=100 → exactly one wr_en with data_out = 100+SYNC_STAGES+1+20 = 123 (count sampled at the latch edge), at the documented cycle.
- Wrap: delay=10, event latched with count=250 → data_out=4, one wr_en.
- Full drop and clear:
  - full=1, three separated pulses → no wr_en, overflow=1, drop_count=3.
  - clear_overflow pulse → both 0.
  - Drop coinciding with clear → overflow=1, drop_count=1.
- Hold-off: HOLDOFF=4, second rise 2 cycles after the first write → ignored (one wr_en). Third rise 8 cycles after → second wr_en; drop_count stays 0.
- Reset mid-event: assert rst_n=0 the cycle data_out latches → no wr_en; after release with pulse_in still high → one new event written.

Source files
------------

// File: rtl/delay_writer.sv
// Write side of the delay-line timestamp FIFO: synchronises pulse_in, detects its rising edge
// and pushes count + delay into the FIFO, with drop accounting and an input hold-off window.
module delay_writer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned DROP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  input  logic [WIDTH-1:0]      count,
  input  logic [WIDTH-1:0]      delay,
  input  logic                  full,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count,
  input  logic                  clear_overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic [1:0]             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;
  logic                   drop_evt;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = data_q;
    drop_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_q) begin
          if (!full) begin
            data_d  = count + delay;
            state_d = WRITE;
          end else begin
            drop_evt = 1'b1;
            if (HOLDOFF != 0) begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
      end
      WRITE: begin
        if (HOLDOFF != 0) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear takes precedence and restarts the count at one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop_evt) begin
      ovf_d = 1'b1;
      if (clear_overflow) begin
        drop_d = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // The edge pulse is registered, so an event is acted on SYNC_STAGES + 1 edges after capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
      state_q <= IDLE;
      hold_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~hist_q;
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_en      = (state_q == WRITE);
  assign data_out   = data_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
